// File: rtl/lif_neuron_gen2.sv
// Leaky integrate-and-fire neuron: saturating integrate, runtime threshold, absolute refractory period.
// Latency: one cycle from an enabled step to the registered state/spike/refractory outputs.
// Backpressure: none; en=0 freezes the neuron. LIF_SPIKE_COUNT_EN adds a saturating spike_count port.
module lif_neuron_gen2 #(
    parameter int WIDTH         = 8,
    parameter int LEAK_SHIFT    = 1,
    parameter int REFRAC_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] current,
    input  logic [WIDTH-1:0] threshold,
    output logic [WIDTH-1:0] state,
    output logic             spike,
`ifdef LIF_SPIKE_COUNT_EN
    output logic [15:0]      spike_count,
`endif
    output logic             refractory
);

    localparam int CW = (REFRAC_CYCLES > 0) ? $clog2(REFRAC_CYCLES + 1) : 1;

    typedef enum logic {INTEG = 1'b0, REFRAC = 1'b1} fsm_t;

    fsm_t             fsm_q, fsm_d;
    logic [WIDTH-1:0] state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             spike_q, spike_d;

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] ns;
    logic             fire;

    // Carry out of the WIDTH+1 bit sum means overflow: clamp to all-ones instead of wrapping.
    assign sum  = {1'b0, current} + {1'b0, state_q >> LEAK_SHIFT};
    assign ns   = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
    assign fire = (ns >= threshold);

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        spike_d = 1'b0;
        if (en) begin
            case (fsm_q)
                INTEG: begin
                    if (fire) begin
                        spike_d = 1'b1;
                        state_d = '0;
                        if (REFRAC_CYCLES > 0) begin
                            fsm_d = REFRAC;
                            cnt_d = CW'(REFRAC_CYCLES);
                        end
                    end else begin
                        state_d = ns;
                    end
                end
                REFRAC: begin
                    state_d = '0;
                    cnt_d   = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        fsm_d = INTEG;
                    end
                end
                default: begin
                    fsm_d = INTEG;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q   <= INTEG;
            state_q <= '0;
            cnt_q   <= '0;
            spike_q <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            spike_q <= spike_d;
        end
    end

`ifdef LIF_SPIKE_COUNT_EN
    logic [15:0] spike_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            spike_count_q <= '0;
        end else if (spike_d && (spike_count_q != 16'hFFFF)) begin
            spike_count_q <= spike_count_q + 16'd1;
        end
    end

    assign spike_count = spike_count_q;
`endif

    assign state      = state_q;
    assign spike      = spike_q;
    assign refractory = (fsm_q == REFRAC);

endmodule
